qar_can_rx_mailbox: RTL and testbench

Parametrised CAN receive mailbox. It sits between the CAN protocol engine and the core's MMIO register file. It replaces the single-frame RX buffer with a multi-entry FIFO, programmable acceptance filters with masks, standard and extended ID support, overrun accounting and a threshold interrupt. Software reads the head frame as ID, data word 0 and data word 1, then pops it.

---
 rtl/qar_can_rx_mailbox.sv | 217 +++++++++++++++++++++
 tb/tb_qar_can_rx_mailbox.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_can_rx_mailbox.sv
// -----------------------------------------------------------------------------
// qar_can_rx_mailbox
//
// CAN receive mailbox between the protocol engine and the MMIO register file.
// Completed frames are passed through a bank of masked acceptance filters.
// Accepted frames are normalised and written into a DEPTH-entry FIFO.
// Normalising means: DLC clamped to 8, bytes beyond the DLC zeroed, and the
// winning filter index recorded. Software reads the head entry and pops it.
// Frames arriving while the FIFO is full are counted as overruns.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_valid            one-cycle strobe: a frame has been received
//   rx_id/rx_ide        frame ID (29 bits) and extended-frame flag
//   rx_dlc/rx_data      data length code and payload (byte0 in [63:56])
//   flt_id/flt_mask     per-filter ID and mask (filter i in slice i*29)
//   flt_ide/flt_en      per-filter required IDE bit and enable
//   pop                 discard the head entry
//   clr_ovr             clear overrun flag and counter
//   irq_en/irq_thresh   interrupt enable and fill threshold
//   head_*              head entry fields (all zero while empty)
//   count/empty/full    occupancy status
//   overrun_flag/cnt    sticky drop flag and saturating drop counter
//   irq                 registered interrupt request
//
// Handshake: rx_valid is a strobe with no back-pressure. A frame is taken
// on the edge where rx_valid is high, or dropped on that edge. pop is honoured
// only when the FIFO is non-empty. The head it removes is the one visible on
// head_* during that cycle.
// -----------------------------------------------------------------------------
module qar_can_rx_mailbox #(
  parameter int DEPTH       = 4,
  parameter int NUM_FILTERS = 2,
  parameter int CNT_W       = 8,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [28:0]               rx_id,
  input  logic                      rx_ide,
  input  logic [3:0]                rx_dlc,
  input  logic [63:0]               rx_data,
  input  logic [NUM_FILTERS*29-1:0] flt_id,
  input  logic [NUM_FILTERS*29-1:0] flt_mask,
  input  logic [NUM_FILTERS-1:0]    flt_ide,
  input  logic [NUM_FILTERS-1:0]    flt_en,
  input  logic                      pop,
  input  logic                      clr_ovr,
  input  logic                      irq_en,
  input  logic [CW-1:0]             irq_thresh,
  output logic [31:0]               head_id,
  output logic [31:0]               head_data0,
  output logic [31:0]               head_data1,
  output logic [3:0]                head_dlc,
  output logic [2:0]                head_hit,
  output logic [CW-1:0]             count,
  output logic                      empty,
  output logic                      full,
  output logic                      overrun_flag,
  output logic [CNT_W-1:0]          overrun_cnt,
  output logic                      irq
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovr_flag_q, ovr_flag_d;
  logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             irq_q, irq_d;

  // Entry storage. Not reset: the pointers and count decide what is valid.
  // The head outputs are forced to zero while empty.
  logic [28:0] mem_id   [DEPTH];
  logic        mem_ide  [DEPTH];
  logic [3:0]  mem_dlc  [DEPTH];
  logic [63:0] mem_data [DEPTH];
  logic [2:0]  mem_hit  [DEPTH];

  // ---------------------------------------------------------------------------
  // Acceptance filtering
  // ---------------------------------------------------------------------------
  logic       match_any;
  logic [2:0] hit_idx;
  logic       filt_any_en;
  logic       accept;

  // Scan from the top down so the lowest matching index is the last to write.
  always_comb begin
    match_any = 1'b0;
    hit_idx   = 3'd0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (flt_en[i] && (flt_ide[i] == rx_ide) &&
          (((rx_id ^ flt_id[i*29 +: 29]) & flt_mask[i*29 +: 29]) == 29'd0)) begin
        match_any = 1'b1;
        hit_idx   = 3'(i);
      end
    end
  end

  // With every filter disabled the mailbox is promiscuous (hit index 0).
  assign filt_any_en = |flt_en;
  assign accept      = rx_valid & (~filt_any_en | match_any);

  // ---------------------------------------------------------------------------
  // Write formatting
  // ---------------------------------------------------------------------------
  logic [3:0]  dlc_clamped;
  logic [63:0] data_fmt;

  assign dlc_clamped = (rx_dlc > 4'd8) ? 4'd8 : rx_dlc;

  // Byte b lives at [63-8b -: 8]. Bytes at or past the DLC are stored as zero.
  always_comb begin
    data_fmt = 64'd0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < dlc_clamped) begin
        data_fmt[63-8*b -: 8] = rx_data[63-8*b -: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic empty_w, full_w;
  logic pop_eff, push_ok, drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign pop_eff = pop & ~empty_w;
  assign push_ok = accept & (~full_w | pop_eff);
  assign drop    = accept & full_w & ~pop_eff;

  logic [CNT_W-1:0] ovr_cnt_base;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_eff);
    count_d  = count_q + CW'(push_ok) - CW'(pop_eff);

    // An overrun in the same cycle as clr_ovr restarts the count at 1.
    ovr_cnt_base = clr_ovr ? '0 : ovr_cnt_q;
    ovr_flag_d   = ovr_flag_q;
    ovr_cnt_d    = ovr_cnt_q;
    if (drop) begin
      ovr_flag_d = 1'b1;
      ovr_cnt_d  = (ovr_cnt_base == '1) ? ovr_cnt_base : ovr_cnt_base + 1'b1;
    end else if (clr_ovr) begin
      ovr_flag_d = 1'b0;
      ovr_cnt_d  = '0;
    end

    irq_d = irq_en & (irq_thresh != '0) &
            ((count_d >= irq_thresh) | ovr_flag_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_flag_q <= 1'b0;
      ovr_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_flag_q <= ovr_flag_d;
      ovr_cnt_q  <= ovr_cnt_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_id[wr_ptr_q]   <= rx_id;
      mem_ide[wr_ptr_q]  <= rx_ide;
      mem_dlc[wr_ptr_q]  <= dlc_clamped;
      mem_data[wr_ptr_q] <= data_fmt;
      mem_hit[wr_ptr_q]  <= hit_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    head_id    = 32'd0;
    head_data0 = 32'd0;
    head_data1 = 32'd0;
    head_dlc   = 4'd0;
    head_hit   = 3'd0;
    if (!empty_w) begin
      head_id    = {mem_ide[rd_ptr_q], 2'b00, mem_id[rd_ptr_q]};
      head_data0 = mem_data[rd_ptr_q][63:32];
      head_data1 = mem_data[rd_ptr_q][31:0];
      head_dlc   = mem_dlc[rd_ptr_q];
      head_hit   = mem_hit[rd_ptr_q];
    end
  end

  assign count        = count_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign overrun_flag = ovr_flag_q;
  assign overrun_cnt  = ovr_cnt_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_qar_can_rx_mailbox.sv
// -----------------------------------------------------------------------------
// Bench for qar_can_rx_mailbox (DEPTH=4, NUM_FILTERS=2, CNT_W=8).
// The driver issues one input set per clock. A reference model of the
// mailbox is kept as a queue plus counters. Accepted frames are pushed
// into exp_q as they are issued. A negedge monitor compares the DUT head
// against exp_q whenever the DUT is non-empty, and pops on pop cycles.
// -----------------------------------------------------------------------------
module tb_qar_can_rx_mailbox;
  localparam int DEPTH = 4;
  localparam int NF    = 2;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OCNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              rx_valid, rx_ide, pop, clr_ovr, irq_en;
  logic [28:0]       rx_id;
  logic [3:0]        rx_dlc;
  logic [63:0]       rx_data;
  logic [NF*29-1:0]  flt_id, flt_mask;
  logic [NF-1:0]     flt_ide, flt_en;
  logic [CW-1:0]     irq_thresh;
  logic [31:0]       head_id, head_data0, head_data1;
  logic [3:0]        head_dlc;
  logic [2:0]        head_hit;
  logic [CW-1:0]     count;
  logic              empty, full, overrun_flag, irq;
  logic [CNT_W-1:0]  overrun_cnt;

  qar_can_rx_mailbox #(.DEPTH(DEPTH), .NUM_FILTERS(NF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_id(rx_id), .rx_ide(rx_ide), .rx_dlc(rx_dlc),
    .rx_data(rx_data),
    .flt_id(flt_id), .flt_mask(flt_mask), .flt_ide(flt_ide), .flt_en(flt_en),
    .pop(pop), .clr_ovr(clr_ovr), .irq_en(irq_en), .irq_thresh(irq_thresh),
    .head_id(head_id), .head_data0(head_data0), .head_data1(head_data1),
    .head_dlc(head_dlc), .head_hit(head_hit),
    .count(count), .empty(empty), .full(full),
    .overrun_flag(overrun_flag), .overrun_cnt(overrun_cnt), .irq(irq)
  );

  // ---------------- configuration (applied on the next issue) ----------------
  logic [28:0]   cf_id   [NF];
  logic [28:0]   cf_mask [NF];
  logic          cf_ide  [NF];
  logic          cf_en   [NF];
  logic          cfg_irq_en;
  int            cfg_thresh;

  // ---------------- reference model ----------------
  // Entry layout: {head_id[31:0], payload[63:0], dlc[3:0], hit[2:0]}
  logic [102:0] exp_q[$];
  int m_cnt, m_ocnt;
  logic m_flag, m_irq;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mdl_accept(input logic [28:0] id, input logic ide,
                                      output logic [2:0] hit);
    logic any_en;
    any_en = 1'b0;
    hit    = 3'd0;
    for (int i = 0; i < NF; i++) if (cf_en[i]) any_en = 1'b1;
    if (!any_en) return 1'b1;
    for (int i = 0; i < NF; i++) begin
      if (cf_en[i] && cf_ide[i] == ide && ((id ^ cf_id[i]) & cf_mask[i]) == 29'd0) begin
        hit = 3'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_status();
    chk("count", 64'(count), 64'(m_cnt));
    chk("empty", 64'(empty), 64'(m_cnt == 0));
    chk("full", 64'(full), 64'(m_cnt == DEPTH));
    chk("overrun_flag", 64'(overrun_flag), 64'(m_flag));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ocnt));
    chk("irq", 64'(irq), 64'(m_irq));
    if (m_cnt == 0) chk("head_id_empty", 64'(head_id), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic v, input logic [28:0] id, input logic ide,
                       input logic [3:0] dlc, input logic [63:0] data,
                       input logic p, input logic c);
    logic [2:0]  hit;
    logic        acc, pop_eff, drop;
    logic [63:0] ones, keep;
    int          d;
    rx_valid = v; rx_id = id; rx_ide = ide; rx_dlc = dlc; rx_data = data;
    pop = p; clr_ovr = c;
    for (int i = 0; i < NF; i++) begin
      flt_id[i*29 +: 29]   = cf_id[i];
      flt_mask[i*29 +: 29] = cf_mask[i];
      flt_ide[i]           = cf_ide[i];
      flt_en[i]            = cf_en[i];
    end
    irq_en = cfg_irq_en;
    irq_thresh = CW'(cfg_thresh);

    pop_eff = p && (m_cnt > 0);
    acc     = mdl_accept(id, ide, hit) && v;
    drop    = 1'b0;
    if (acc) begin
      if (m_cnt < DEPTH || pop_eff) begin
        d    = (dlc > 4'd8) ? 8 : int'(dlc);
        ones = '1;
        keep = ~(ones >> (8 * d));
        exp_q.push_back({ide, 2'b00, id, data & keep, 4'(d), hit});
        m_cnt++;
      end else begin
        drop = 1'b1;
      end
    end
    if (pop_eff) m_cnt--;
    if (drop) begin
      m_flag = 1'b1;
      if (c) m_ocnt = 1;
      else if (m_ocnt < OCNT_MAX) m_ocnt++;
    end else if (c) begin
      m_flag = 1'b0;
      m_ocnt = 0;
    end
    m_irq = cfg_irq_en && (cfg_thresh != 0) && ((m_cnt >= cfg_thresh) || m_flag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic step(input logic v, input logic [28:0] id, input logic ide,
                      input logic [3:0] dlc, input logic [63:0] data,
                      input logic p, input logic c);
    tick();
    issue(v, id, ide, dlc, data, p, c);
  endtask

  task automatic push(input logic [28:0] id, input logic ide, input logic [3:0] dlc,
                      input logic [63:0] data);
    step(1'b1, id, ide, dlc, data, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 29'd0, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 29'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic async_reset();
    @(posedge clk);
    #1;
    check_status();
    #2;
    rst_n = 1'b0;
    rx_valid = 1'b0; pop = 1'b0; clr_ovr = 1'b0;
    m_cnt = 0; m_ocnt = 0; m_flag = 1'b0; m_irq = 1'b0;
    exp_q.delete();
    #1;
    check_status();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [102:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_present actual=nonempty expected=empty at %0t", $time);
      end else begin
        mon_e = exp_q[0];
        chk("head_id", 64'(head_id), 64'(mon_e[102:71]));
        chk("head_data0", 64'(head_data0), 64'(mon_e[70:39]));
        chk("head_data1", 64'(head_data1), 64'(mon_e[38:7]));
        chk("head_dlc", 64'(head_dlc), 64'(mon_e[6:3]));
        chk("head_hit", 64'(head_hit), 64'(mon_e[2:0]));
        if (pop) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NF; i++) begin
      cf_id[i] = '0; cf_mask[i] = '0; cf_ide[i] = 1'b0; cf_en[i] = 1'b0;
    end
    cfg_irq_en = 1'b0; cfg_thresh = 0;
    m_cnt = 0; m_ocnt = 0; m_flag = 1'b0; m_irq = 1'b0;
    rst_n = 1'b0;
    issue(1'b0, 29'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
    #3;
    check_status();
    #10;
    rst_n = 1'b1;

    // Filters disabled: standard frame, DLC 4
    push(29'h123, 1'b0, 4'd4, 64'hDEADBEEF_11223344);
    idle(1);
    pop_one();
    idle(1);

    // Filter 0: standard 0x321 exact
    cf_en[0] = 1'b1; cf_id[0] = 29'h321; cf_mask[0] = 29'h7FF; cf_ide[0] = 1'b0;
    push(29'h321, 1'b0, 4'd8, 64'hCAFEBABE_01020304);
    push(29'h322, 1'b0, 4'd8, 64'h1111_2222_3333_4444);
    idle(1);
    pop_one();

    // Filter 1: extended exact; same ID as a standard frame must be rejected
    cf_en[1] = 1'b1; cf_id[1] = 29'h1ABCDEF0; cf_mask[1] = 29'h1FFFFFFF; cf_ide[1] = 1'b1;
    push(29'h1ABCDEF0, 1'b1, 4'd15, rnd64());
    push(29'h1ABCDEF0, 1'b0, 4'd8, rnd64());
    idle(1);
    pop_one();

    // Overrun: 6 frames into 4 slots, drain in order, then clear
    cf_en[0] = 1'b0; cf_en[1] = 1'b0;
    for (int k = 0; k < 6; k++) push(29'(k + 1), 1'b0, 4'(k + 3), rnd64());
    idle(1);
    for (int k = 0; k < 4; k++) pop_one();
    step(1'b0, 29'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
    idle(1);

    // Full FIFO with simultaneous push and pop; pop+push while empty
    for (int k = 0; k < 4; k++) push(29'(k + 16), 1'b0, 4'd8, rnd64());
    step(1'b1, 29'h7AA, 1'b0, 4'd2, rnd64(), 1'b1, 1'b0);
    idle(1);
    for (int k = 0; k < 4; k++) pop_one();
    step(1'b1, 29'h055, 1'b0, 4'd0, rnd64(), 1'b1, 1'b0);
    idle(1);
    pop_one();

    // Overrun counter saturation, then clr_ovr colliding with an overrun
    for (int k = 0; k < 4; k++) push(29'(k + 32), 1'b0, 4'd1, rnd64());
    for (int k = 0; k < 260; k++) push(29'h100, 1'b0, 4'd1, rnd64());
    step(1'b1, 29'h101, 1'b0, 4'd1, rnd64(), 1'b0, 1'b1);
    step(1'b0, 29'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) pop_one();

    // Threshold interrupt
    cfg_irq_en = 1'b1; cfg_thresh = 2;
    push(29'h201, 1'b0, 4'd8, rnd64());
    push(29'h202, 1'b0, 4'd8, rnd64());
    idle(1);
    pop_one();
    push(29'h203, 1'b0, 4'd8, rnd64());
    idle(1);
    async_reset();
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        for (int i = 0; i < NF; i++) begin
          cf_en[i]   = 1'($urandom_range(0, 1));
          cf_id[i]   = 29'($urandom_range(0, 15));
          cf_mask[i] = 29'($urandom_range(0, 15));
          cf_ide[i]  = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 63) == 0) begin
        cfg_irq_en = 1'($urandom_range(0, 1));
        cfg_thresh = $urandom_range(0, DEPTH);
      end
      step(1'($urandom_range(0, 1)), 29'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd64(),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end
    idle(2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
